// File: rtl/biriscv_branch_arb_pkg.sv
// Shared entry layout for the branch predictor update queue.
// Each 69-bit entry is {source[31:0], pc[31:0], taken, not_taken, call, ret, jmp}, MSB first.
package biriscv_branch_arb_pkg;

  localparam int BP_SOURCE_W = 32;
  localparam int BP_PC_W     = 32;
  localparam int BP_ATTR_W   = 5;
  localparam int BP_ENTRY_W  = BP_SOURCE_W + BP_PC_W + BP_ATTR_W;

  typedef struct packed {
    logic [BP_SOURCE_W-1:0] source;
    logic [BP_PC_W-1:0]     pc;
    logic                   taken;
    logic                   not_taken;
    logic                   call;
    logic                   ret;
    logic                   jmp;
  } bp_entry_t;

  // Add 0..2 drops to an 8-bit counter, clamping at 255.
  function automatic logic [7:0] sat_add_drops(input logic [7:0] count, input logic [1:0] drops);
    logic [8:0] sum;
    sum = {1'b0, count} + {7'd0, drops};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/biriscv_branch_fifo.sv
// Two-write, one-read storage for predictor updates.
// Slot 0 is written at the write pointer and slot 1 after it; push1_i is only ever set together with push0_i.
module biriscv_branch_fifo
  import biriscv_branch_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push0_i,
  input  logic          push1_i,
  input  bp_entry_t     data0_i,
  input  bp_entry_t     data1_i,
  input  logic          pop_i,
  output bp_entry_t     head_o,
  output logic [LW-1:0] level_o
);

  bp_entry_t     ram_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [PW-1:0] wr_ptr_next;

  assign wr_ptr_next = wr_ptr_q + PW'(1);

  // Data storage carries no reset; its contents only matter while level is non-zero.
  always_ff @(posedge clk_i) begin
    if (push0_i)
      ram_q[wr_ptr_q] <= data0_i;
    if (push1_i)
      ram_q[wr_ptr_next] <= data1_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PW'(push0_i) + PW'(push1_i);
      rd_ptr_q <= rd_ptr_q + PW'(pop_i);
      level_q  <= level_q + LW'(push0_i) + LW'(push1_i) - LW'(pop_i);
    end
  end

  assign head_o  = ram_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/biriscv_branch_arb.sv
// Merges resolved branches from two issue lanes into the predictor update queue.
// When space runs short the younger lane (lane1) is discarded first, and every discard is counted.
module biriscv_branch_arb
  import biriscv_branch_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,

  input  logic          lane0_request_i,
  input  logic          lane0_is_taken_i,
  input  logic          lane0_is_not_taken_i,
  input  logic          lane0_is_call_i,
  input  logic          lane0_is_ret_i,
  input  logic          lane0_is_jmp_i,
  input  logic [31:0]   lane0_source_i,
  input  logic [31:0]   lane0_pc_i,

  input  logic          lane1_request_i,
  input  logic          lane1_is_taken_i,
  input  logic          lane1_is_not_taken_i,
  input  logic          lane1_is_call_i,
  input  logic          lane1_is_ret_i,
  input  logic          lane1_is_jmp_i,
  input  logic [31:0]   lane1_source_i,
  input  logic [31:0]   lane1_pc_i,

  output logic          bp_valid_o,
  input  logic          bp_ready_i,
  output logic          bp_is_taken_o,
  output logic          bp_is_not_taken_o,
  output logic          bp_is_call_o,
  output logic          bp_is_ret_o,
  output logic          bp_is_jmp_o,
  output logic [31:0]   bp_source_o,
  output logic [31:0]   bp_pc_o,

  output logic          stall_o,
  output logic [7:0]    drop_count_o,
  output logic [LW-1:0] level_o
);

  localparam logic [LW:0] DEPTH_L = (LW+1)'(DEPTH);

  bp_entry_t   lane0_entry;
  bp_entry_t   lane1_entry;
  bp_entry_t   slot0_entry;
  bp_entry_t   head;
  logic [LW-1:0] level;
  logic [LW:0] free;
  logic        pop;
  logic        accept0;
  logic        accept1;
  logic [1:0]  drops;
  logic [7:0]  drop_count_q;

  assign lane0_entry = '{source: lane0_source_i, pc: lane0_pc_i, taken: lane0_is_taken_i,
                         not_taken: lane0_is_not_taken_i, call: lane0_is_call_i,
                         ret: lane0_is_ret_i, jmp: lane0_is_jmp_i};
  assign lane1_entry = '{source: lane1_source_i, pc: lane1_pc_i, taken: lane1_is_taken_i,
                         not_taken: lane1_is_not_taken_i, call: lane1_is_call_i,
                         ret: lane1_is_ret_i, jmp: lane1_is_jmp_i};

  assign pop  = bp_valid_o & bp_ready_i;
  // A pop in the same cycle frees its slot for this cycle's pushes.
  assign free = DEPTH_L - {1'b0, level} + (LW+1)'(pop);

  always_comb begin
    accept0 = 1'b0;
    accept1 = 1'b0;
    if (lane0_request_i && lane1_request_i) begin
      accept0 = (free >= (LW+1)'(1));
      accept1 = (free >= (LW+1)'(2));
    end else if (lane0_request_i) begin
      accept0 = (free >= (LW+1)'(1));
    end else if (lane1_request_i) begin
      accept1 = (free >= (LW+1)'(1));
    end
  end

  assign drops       = 2'(lane0_request_i & ~accept0) + 2'(lane1_request_i & ~accept1);
  assign slot0_entry = accept0 ? lane0_entry : lane1_entry;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      drop_count_q <= 8'd0;
    else
      drop_count_q <= sat_add_drops(drop_count_q, drops);
  end

  biriscv_branch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push0_i (accept0 | accept1),
    .push1_i (accept0 & accept1),
    .data0_i (slot0_entry),
    .data1_i (lane1_entry),
    .pop_i   (pop),
    .head_o  (head),
    .level_o (level)
  );

  assign bp_valid_o        = (level != '0);
  assign bp_is_taken_o     = head.taken;
  assign bp_is_not_taken_o = head.not_taken;
  assign bp_is_call_o      = head.call;
  assign bp_is_ret_o       = head.ret;
  assign bp_is_jmp_o       = head.jmp;
  assign bp_source_o       = head.source;
  assign bp_pc_o           = head.pc;

  assign stall_o      = (level > LW'(DEPTH - 2));
  assign drop_count_o = drop_count_q;
  assign level_o      = level;

endmodule

// File: tb/tb_biriscv_branch_arb.sv
// Directed self-checking bench for biriscv_branch_arb at DEPTH=4.
module tb_biriscv_branch_arb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lane0_request_i, lane0_is_taken_i, lane0_is_not_taken_i, lane0_is_call_i, lane0_is_ret_i, lane0_is_jmp_i;
  logic [31:0] lane0_source_i, lane0_pc_i;
  logic        lane1_request_i, lane1_is_taken_i, lane1_is_not_taken_i, lane1_is_call_i, lane1_is_ret_i, lane1_is_jmp_i;
  logic [31:0] lane1_source_i, lane1_pc_i;
  logic        bp_valid_o, bp_ready_i;
  logic        bp_is_taken_o, bp_is_not_taken_o, bp_is_call_o, bp_is_ret_o, bp_is_jmp_o;
  logic [31:0] bp_source_o, bp_pc_o;
  logic        stall_o;
  logic [7:0]  drop_count_o;
  logic [2:0]  level_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  biriscv_branch_arb #(.DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lane0_request_i(lane0_request_i), .lane0_is_taken_i(lane0_is_taken_i),
    .lane0_is_not_taken_i(lane0_is_not_taken_i), .lane0_is_call_i(lane0_is_call_i),
    .lane0_is_ret_i(lane0_is_ret_i), .lane0_is_jmp_i(lane0_is_jmp_i),
    .lane0_source_i(lane0_source_i), .lane0_pc_i(lane0_pc_i),
    .lane1_request_i(lane1_request_i), .lane1_is_taken_i(lane1_is_taken_i),
    .lane1_is_not_taken_i(lane1_is_not_taken_i), .lane1_is_call_i(lane1_is_call_i),
    .lane1_is_ret_i(lane1_is_ret_i), .lane1_is_jmp_i(lane1_is_jmp_i),
    .lane1_source_i(lane1_source_i), .lane1_pc_i(lane1_pc_i),
    .bp_valid_o(bp_valid_o), .bp_ready_i(bp_ready_i),
    .bp_is_taken_o(bp_is_taken_o), .bp_is_not_taken_o(bp_is_not_taken_o),
    .bp_is_call_o(bp_is_call_o), .bp_is_ret_o(bp_is_ret_o), .bp_is_jmp_o(bp_is_jmp_o),
    .bp_source_o(bp_source_o), .bp_pc_o(bp_pc_o),
    .stall_o(stall_o), .drop_count_o(drop_count_o), .level_o(level_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_lane0(input logic req, input logic [31:0] src, input logic [31:0] pc, input logic [4:0] attr);
    lane0_request_i = req; lane0_source_i = src; lane0_pc_i = pc;
    {lane0_is_taken_i, lane0_is_not_taken_i, lane0_is_call_i, lane0_is_ret_i, lane0_is_jmp_i} = attr;
  endtask

  task automatic set_lane1(input logic req, input logic [31:0] src, input logic [31:0] pc, input logic [4:0] attr);
    lane1_request_i = req; lane1_source_i = src; lane1_pc_i = pc;
    {lane1_is_taken_i, lane1_is_not_taken_i, lane1_is_call_i, lane1_is_ret_i, lane1_is_jmp_i} = attr;
  endtask

  task automatic idle_lanes();
    set_lane0(1'b0, 32'h0, 32'h0, 5'b0);
    set_lane1(1'b0, 32'h0, 32'h0, 5'b0);
  endtask

  task automatic dual_push(input logic [31:0] s0, input logic [31:0] s1);
    set_lane0(1'b1, s0, s0 + 32'h1000, 5'b10000);
    set_lane1(1'b1, s1, s1 + 32'h1000, 5'b01000);
    tick();
    idle_lanes();
  endtask

  task automatic test_reset();
    idle_lanes();
    bp_ready_i = 1'b0;
    rst_i = 1'b1;
    #12;
    checks++; if (bp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%0b exp=0", bp_valid_o); end
    checks++; if (level_o !== 3'd0) begin errors++; $display("[TB] FAIL reset_level got=%0d exp=0", level_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got=%0b exp=0", stall_o); end
    checks++; if (drop_count_o !== 8'd0) begin errors++; $display("[TB] FAIL reset_drops got=%0d exp=0", drop_count_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_single_lane();
    bp_ready_i = 1'b1;
    set_lane0(1'b1, 32'h100, 32'h200, 5'b10000);
    #1;
    checks++; if (bp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL single_no_bypass got=%0b exp=0", bp_valid_o); end
    tick();
    idle_lanes();
    checks++; if (bp_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got=%0b exp=1", bp_valid_o); end
    checks++; if (bp_source_o !== 32'h100) begin errors++; $display("[TB] FAIL single_source got=%h exp=00000100", bp_source_o); end
    checks++; if (bp_pc_o !== 32'h200) begin errors++; $display("[TB] FAIL single_pc got=%h exp=00000200", bp_pc_o); end
    checks++; if (bp_is_taken_o !== 1'b1) begin errors++; $display("[TB] FAIL single_taken got=%0b exp=1", bp_is_taken_o); end
    tick();
    checks++; if (bp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL single_popped got=%0b exp=0", bp_valid_o); end
  endtask

  task automatic test_dual_lane();
    bp_ready_i = 1'b0;
    set_lane0(1'b1, 32'h10, 32'h50, 5'b10000);
    set_lane1(1'b1, 32'h14, 32'h60, 5'b11101);
    tick();
    idle_lanes();
    checks++; if (level_o !== 3'd2) begin errors++; $display("[TB] FAIL dual_level got=%0d exp=2", level_o); end
    checks++; if (bp_source_o !== 32'h10) begin errors++; $display("[TB] FAIL dual_head0 got=%h exp=00000010", bp_source_o); end
    tick();
    checks++; if (bp_source_o !== 32'h10) begin errors++; $display("[TB] FAIL dual_head_stable got=%h exp=00000010", bp_source_o); end
    bp_ready_i = 1'b1;
    tick();
    bp_ready_i = 1'b0;
    checks++; if (bp_source_o !== 32'h14) begin errors++; $display("[TB] FAIL dual_head1 got=%h exp=00000014", bp_source_o); end
    checks++; if (bp_pc_o !== 32'h60) begin errors++; $display("[TB] FAIL dual_pc1 got=%h exp=00000060", bp_pc_o); end
    checks++;
    if ({bp_is_taken_o, bp_is_not_taken_o, bp_is_call_o, bp_is_ret_o, bp_is_jmp_o} !== 5'b11101) begin
      errors++;
      $display("[TB] FAIL dual_attr1 got=%b exp=11101", {bp_is_taken_o, bp_is_not_taken_o, bp_is_call_o, bp_is_ret_o, bp_is_jmp_o});
    end
    checks++; if (level_o !== 3'd1) begin errors++; $display("[TB] FAIL dual_level_after_pop got=%0d exp=1", level_o); end
    bp_ready_i = 1'b1;
    tick();
    bp_ready_i = 1'b0;
  endtask

  task automatic test_invalid_strobe();
    set_lane0(1'b0, 32'hDEAD, 32'hBEEF, 5'b11111);
    set_lane1(1'b0, 32'hCAFE, 32'hF00D, 5'b11111);
    tick();
    idle_lanes();
    checks++; if (level_o !== 3'd0) begin errors++; $display("[TB] FAIL invalid_no_write got=%0d exp=0", level_o); end
  endtask

  task automatic test_overflow();
    bp_ready_i = 1'b0;
    dual_push(32'h20, 32'h24);
    checks++; if (level_o !== 3'd2 || stall_o !== 1'b0) begin errors++; $display("[TB] FAIL ovf_cycle1 got level=%0d stall=%0b exp level=2 stall=0", level_o, stall_o); end
    dual_push(32'h28, 32'h2c);
    checks++; if (level_o !== 3'd4 || stall_o !== 1'b1 || drop_count_o !== 8'd0) begin errors++; $display("[TB] FAIL ovf_cycle2 got level=%0d stall=%0b drops=%0d exp 4/1/0", level_o, stall_o, drop_count_o); end
    dual_push(32'h30, 32'h34);
    checks++; if (level_o !== 3'd4 || drop_count_o !== 8'd2) begin errors++; $display("[TB] FAIL ovf_cycle3 got level=%0d drops=%0d exp 4/2", level_o, drop_count_o); end
    bp_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bp_source_o !== 32'h20 + 32'(4*i)) begin errors++; $display("[TB] FAIL ovf_order%0d got=%h exp=%h", i, bp_source_o, 32'h20 + 32'(4*i)); end
      tick();
    end
    bp_ready_i = 1'b0;
    checks++; if (level_o !== 3'd0) begin errors++; $display("[TB] FAIL ovf_drained got=%0d exp=0", level_o); end
  endtask

  task automatic test_lane_priority();
    bp_ready_i = 1'b0;
    set_lane0(1'b1, 32'h40, 32'h1040, 5'b10000);
    tick();
    idle_lanes();
    checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL prio_stall_l1 got=%0b exp=0", stall_o); end
    dual_push(32'h44, 32'h48);
    checks++; if (level_o !== 3'd3 || stall_o !== 1'b1) begin errors++; $display("[TB] FAIL prio_level3 got level=%0d stall=%0b exp 3/1", level_o, stall_o); end
    dual_push(32'h4c, 32'h50);
    checks++; if (level_o !== 3'd4 || drop_count_o !== 8'd3) begin errors++; $display("[TB] FAIL prio_one_drop got level=%0d drops=%0d exp 4/3", level_o, drop_count_o); end
  endtask

  task automatic test_full_with_pop();
    logic [31:0] exp_order [4];
    exp_order[0] = 32'h44; exp_order[1] = 32'h48; exp_order[2] = 32'h4c; exp_order[3] = 32'h54;
    bp_ready_i = 1'b1;
    dual_push(32'h54, 32'h58);
    checks++; if (level_o !== 3'd4 || drop_count_o !== 8'd4) begin errors++; $display("[TB] FAIL fullpop got level=%0d drops=%0d exp 4/4", level_o, drop_count_o); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bp_source_o !== exp_order[i]) begin errors++; $display("[TB] FAIL fullpop_order%0d got=%h exp=%h", i, bp_source_o, exp_order[i]); end
      tick();
    end
    checks++; if (bp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL fullpop_empty got=%0b exp=0", bp_valid_o); end
    bp_ready_i = 1'b0;
  endtask

  task automatic test_saturation();
    bp_ready_i = 1'b0;
    dual_push(32'h60, 32'h64);
    dual_push(32'h68, 32'h6c);
    for (int i = 0; i < 150; i++)
      dual_push(32'h70, 32'h74);
    checks++; if (drop_count_o !== 8'd255) begin errors++; $display("[TB] FAIL saturation got=%0d exp=255", drop_count_o); end
    checks++; if (level_o !== 3'd4) begin errors++; $display("[TB] FAIL saturation_level got=%0d exp=4", level_o); end
  endtask

  task automatic test_async_reset();
    bp_ready_i = 1'b1;
    tick();
    bp_ready_i = 1'b0;
    checks++; if (level_o !== 3'd3) begin errors++; $display("[TB] FAIL areset_pre_level got=%0d exp=3", level_o); end
    #3;
    rst_i = 1'b1;
    #1;
    checks++; if (bp_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL areset_valid got=%0b exp=0", bp_valid_o); end
    checks++; if (level_o !== 3'd0) begin errors++; $display("[TB] FAIL areset_level got=%0d exp=0", level_o); end
    checks++; if (drop_count_o !== 8'd0) begin errors++; $display("[TB] FAIL areset_drops got=%0d exp=0", drop_count_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("[TB] FAIL areset_stall got=%0b exp=0", stall_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_dual_lane();
    test_invalid_strobe();
    test_overflow();
    test_lane_priority();
    test_full_with_pop();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
